// File: rtl/fir_symmetric_param_pkg.sv
// Shared widths, loader state encoding and output saturation for the symmetric FIR.
package fir_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int COEF_W_DEF     = 8;
  localparam int NUM_UNIQUE_DEF = 3;
  localparam int OUT_W_DEF      = 11;

  localparam int TAPS   = 2 * NUM_UNIQUE_DEF;
  localparam int PRE_W  = DATA_W_DEF + 1;
  localparam int PROD_W = DATA_W_DEF + COEF_W_DEF + 1;
  localparam int SUM_W  = PROD_W + $clog2(NUM_UNIQUE_DEF);

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_LOAD   = 2'd1,
    LD_COMMIT = 2'd2
  } ld_state_t;

  // Clamp a sign-extended accumulator to the signed out_w range.
  function automatic logic signed [63:0] sat_to_outw(input logic signed [63:0] v,
                                                      input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/fir_symmetric_param_if.sv
// Sample/coefficient input and filtered output bundle of the symmetric FIR.
interface fir_symmetric_param_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 11
);
  logic signed [DATA_W-1:0] x_n;
  logic                     s_axis_fir_tvalid;
  logic                     s_set_coeffs;
  logic signed [OUT_W-1:0]  o_y_n;
  logic                     o_valid;
  logic                     o_busy;

  modport master (
    output x_n, s_axis_fir_tvalid, s_set_coeffs,
    input  o_y_n, o_valid, o_busy
  );

  modport slave (
    input  x_n, s_axis_fir_tvalid, s_set_coeffs,
    output o_y_n, o_valid, o_busy
  );
endinterface

// File: rtl/fir_coef_loader.sv
// Coefficient load FSM: collects NUM_UNIQUE words into a shadow set and commits
// them atomically on the cycle the last word arrives; an early drop discards the shadow.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int COEF_W     = COEF_W_DEF,
  parameter int NUM_UNIQUE = NUM_UNIQUE_DEF,
  parameter logic [NUM_UNIQUE*COEF_W-1:0] DEFAULT_COEFS = {8'sd3, 8'sd2, 8'sd1}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         set_coeffs,
  input  logic [DATA_W-1:0]            word,
  output logic [NUM_UNIQUE*COEF_W-1:0] coefs,
  output logic                         commit,
  output logic                         busy
);

  localparam int CNT_W = $clog2(NUM_UNIQUE + 1);

  ld_state_t                    state;
  logic [CNT_W-1:0]             cnt;
  logic [NUM_UNIQUE*COEF_W-1:0] shadow;
  logic [NUM_UNIQUE*COEF_W-1:0] shadow_nxt;
  logic                         capture;

  // cnt is 0 in IDLE, so the first word lands in slot 0 on the same edge.
  always_comb begin
    capture    = set_coeffs && (state != LD_COMMIT) && (int'(cnt) < NUM_UNIQUE);
    commit     = capture && (int'(cnt) == NUM_UNIQUE - 1);
    shadow_nxt = shadow;
    for (int k = 0; k < NUM_UNIQUE; k++) begin
      if (capture && (int'(cnt) == k))
        shadow_nxt[k*COEF_W +: COEF_W] = word[COEF_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= LD_IDLE;
      cnt    <= '0;
      shadow <= '0;
      coefs  <= DEFAULT_COEFS;
    end else begin
      shadow <= shadow_nxt;
      if (commit)
        coefs <= shadow_nxt;
      case (state)
        LD_IDLE, LD_LOAD: begin
          if (set_coeffs) begin
            cnt   <= cnt + CNT_W'(1);
            state <= commit ? LD_COMMIT : LD_LOAD;
          end else begin
            cnt   <= '0;
            state <= LD_IDLE;
          end
        end
        LD_COMMIT: begin
          if (!set_coeffs) begin
            cnt   <= '0;
            state <= LD_IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= LD_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != LD_IDLE);

endmodule

// File: rtl/fir_symmetric_param.sv
// Even-length linear-phase FIR: pre-add, multiply, sum+saturate, one register each,
// so o_y_n/o_valid follow an accepted sample by three edges after it enters x[0].
module fir_symmetric_param
  import fir_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int COEF_W     = COEF_W_DEF,
  parameter int NUM_UNIQUE = NUM_UNIQUE_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter logic [NUM_UNIQUE*COEF_W-1:0] DEFAULT_COEFS = {8'sd3, 8'sd2, 8'sd1}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fir_symmetric_param_if.slave bus
);

  localparam int N_TAPS = 2 * NUM_UNIQUE;
  localparam int PRE_N  = DATA_W + 1;
  localparam int PROD_N = DATA_W + COEF_W + 1;
  localparam int SUM_N  = PROD_N + $clog2(NUM_UNIQUE);

  logic [NUM_UNIQUE*COEF_W-1:0] coefs;
  logic                         commit;
  logic                         accept;

  logic signed [DATA_W-1:0] x_dl [N_TAPS];
  logic signed [PRE_N-1:0]  pre  [NUM_UNIQUE];
  logic signed [PROD_N-1:0] prod [NUM_UNIQUE];
  logic signed [SUM_N-1:0]  sum;
  logic signed [63:0]       sat_full;
  logic                     acc_v;
  logic                     v1;
  logic                     v2;

  fir_coef_loader #(
    .DATA_W        (DATA_W),
    .COEF_W        (COEF_W),
    .NUM_UNIQUE    (NUM_UNIQUE),
    .DEFAULT_COEFS (DEFAULT_COEFS)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_coeffs (bus.s_set_coeffs),
    .word       (bus.x_n),
    .coefs      (coefs),
    .commit     (commit),
    .busy       (bus.o_busy)
  );

  assign accept = bus.s_axis_fir_tvalid & ~bus.s_set_coeffs;

  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_UNIQUE; k++)
      sum = sum + SUM_N'(prod[k]);
    sat_full = sat_to_outw(64'(sum), OUT_W);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++)
        x_dl[k] <= '0;
      for (int k = 0; k < NUM_UNIQUE; k++) begin
        pre[k]  <= '0;
        prod[k] <= '0;
      end
      acc_v       <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_y_n   <= '0;
    end else begin
      // A commit flushes old-coefficient history; accept is never high on that edge.
      if (commit) begin
        for (int k = 0; k < N_TAPS; k++)
          x_dl[k] <= '0;
      end else if (accept) begin
        x_dl[0] <= bus.x_n;
        for (int k = 1; k < N_TAPS; k++)
          x_dl[k] <= x_dl[k-1];
      end

      for (int k = 0; k < NUM_UNIQUE; k++) begin
        pre[k]  <= PRE_N'(x_dl[k]) + PRE_N'(x_dl[N_TAPS-1-k]);
        prod[k] <= PROD_N'(pre[k]) * PROD_N'($signed(coefs[k*COEF_W +: COEF_W]));
      end

      acc_v       <= accept & ~commit;
      v1          <= acc_v & ~commit;
      v2          <= v1 & ~commit;
      bus.o_valid <= v2 & ~commit;
      if (v2)
        bus.o_y_n <= sat_full[OUT_W-1:0];
    end
  end

endmodule
